// File: rtl/adp_bscan_ctrl_if.sv
// Command/response handshake bundle for the boundary-scan controller.
// The master issues commands and takes responses; the slave is the controller.
interface adp_bscan_ctrl_if #(
  parameter int NUM_CELLS = 49
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [NUM_CELLS-1:0] cmd_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [NUM_CELLS-1:0] rsp_data;
  logic                 rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/adp_bscan_ctrl.sv
// Boundary-scan chain controller: sequences capture/shift/update on a
// NUM_CELLS-long chain per command and returns the serially read-out data.
module adp_bscan_ctrl #(
  parameter int NUM_CELLS = 49
) (
  input  logic            clk,
  input  logic            rst,
  adp_bscan_ctrl_if.slave bus,
  output logic            adp_bscan_start,
  output logic            adp_bscan_se,
  output logic            adp_bscan_shift_sel,
  output logic            adp_bscan_oe,
  output logic            adp_bscan_out_sel,
  input  logic            adp_bscan_end
);
  localparam int CNT_W = $clog2(NUM_CELLS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CELLS - 1);

  localparam logic [1:0] OP_SCAN  = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_MODE  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHIFT   = 3'd2,
    UPDATE  = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [NUM_CELLS-1:0] tx_q, tx_d;
  logic [NUM_CELLS-1:0] rx_q, rx_d;
  logic                 err_q, err_d;
  logic                 out_sel_q, out_sel_d;

  // tx_q shifts MSB-first onto start; rx_q fills from the LSB so the first bit read lands in the MSB
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    err_d     = err_q;
    out_sel_d = out_sel_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.cmd_valid) begin
          op_d  = bus.cmd_op;
          tx_d  = bus.cmd_data;
          err_d = (bus.cmd_op == OP_RSVD);
          case (bus.cmd_op)
            OP_SCAN:  state_d = CAPTURE;
            OP_SHIFT: state_d = SHIFT;
            OP_MODE: begin
              state_d   = RESP;
              out_sel_d = bus.cmd_data[0];
            end
            default:  state_d = RESP;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        tx_d = {tx_q[NUM_CELLS-2:0], 1'b0};
        rx_d = {rx_q[NUM_CELLS-2:0], adp_bscan_end};
        if (cnt_q == CNT_LAST) begin
          state_d = (op_q == OP_SCAN) ? UPDATE : RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = SHIFT;
        end
      end
      UPDATE: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_SCAN;
      tx_q      <= '0;
      rx_q      <= '0;
      err_q     <= 1'b0;
      out_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      err_q     <= err_d;
      out_sel_q <= out_sel_d;
    end
  end

  // Chain strobes decode only from the state register, so reset silences them at once
  always_comb begin
    bus.cmd_ready       = 1'b0;
    bus.rsp_valid       = 1'b0;
    adp_bscan_start     = 1'b0;
    adp_bscan_se        = 1'b0;
    adp_bscan_shift_sel = 1'b0;
    adp_bscan_oe        = 1'b0;
    case (state_q)
      IDLE:    bus.cmd_ready = 1'b1;
      CAPTURE: adp_bscan_se  = 1'b1;
      SHIFT: begin
        adp_bscan_se        = 1'b1;
        adp_bscan_shift_sel = 1'b1;
        adp_bscan_start     = tx_q[NUM_CELLS-1];
      end
      UPDATE:  adp_bscan_oe  = 1'b1;
      RESP:    bus.rsp_valid = 1'b1;
      default: bus.cmd_ready = 1'b0;
    endcase
  end

  assign bus.rsp_data      = rx_q;
  assign bus.rsp_err       = err_q;
  assign adp_bscan_out_sel = out_sel_q;
endmodule

// File: tb/tb_adp_bscan_ctrl.sv
// Randomized bench for adp_bscan_ctrl: a behavioural scan chain with pins
// drives the DUT, and an abstract model predicts responses and pin state.
module tb_adp_bscan_ctrl;
  localparam int N = 49;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adp_bscan_ctrl_if #(.NUM_CELLS(N)) bus ();

  logic start, se, shift_sel, oe, out_sel, chain_end;
  logic [N-1:0] cells = '0;
  logic [N-1:0] upd = '0;
  logic [N-1:0] func_pins = '0;
  logic [N-1:0] pins;

  adp_bscan_ctrl #(.NUM_CELLS(N)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .adp_bscan_start     (start),
    .adp_bscan_se        (se),
    .adp_bscan_shift_sel (shift_sel),
    .adp_bscan_oe        (oe),
    .adp_bscan_out_sel   (out_sel),
    .adp_bscan_end       (chain_end)
  );

  // Physical chain: cell 0 takes start, cell N-1 drives end
  assign pins      = out_sel ? upd : func_pins;
  assign chain_end = cells[N-1];
  always @(posedge clk) begin
    if (se && shift_sel) cells <= {cells[N-2:0], start};
    else if (se)         cells <= pins;
    if (oe) upd <= cells;
  end

  // Abstract model: what the chain and update register hold after each command
  logic [N-1:0] chain_m = '0;
  logic [N-1:0] upd_m = '0;
  logic [N-1:0] last_rsp_m = '0;
  logic         out_sel_m = 1'b0;
  bit           chain_ok = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [N-1:0] rand_vec();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[N-1:0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_se"},        64'(se), 64'd0);
    check_eq({tag, "_oe"},        64'(oe), 64'd0);
    check_eq({tag, "_shift_sel"}, 64'(shift_sel), 64'd0);
    check_eq({tag, "_start"},     64'(start), 64'd0);
    check_eq({tag, "_out_sel"},   64'(out_sel), 64'd0);
    check_eq({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    check_eq({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check_eq({tag, "_rsp_err"},   64'(bus.rsp_err), 64'd0);
    check_eq({tag, "_rsp_data"},  64'(bus.rsp_data), 64'd0);
  endtask

  // One full command; inject > 0 asserts reset at that cycle after accept and aborts
  task automatic do_cmd(input logic [1:0] op, input logic [N-1:0] data,
                        input int hold, input bit noise, input int inject);
    logic [N-1:0] exp_rsp, new_chain, new_upd;
    logic new_out_sel;
    int n, se_n, sh_n, oe_n, oe_at, bad_start, exp_lat, w;
    bit got, check_data;

    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w == 20) check_eq("ready_timeout", 64'(bus.cmd_ready), 64'd1);

    new_chain = chain_m; new_upd = upd_m; new_out_sel = out_sel_m;
    exp_rsp = last_rsp_m; check_data = 1'b1;
    case (op)
      2'b00: begin
        exp_rsp = out_sel_m ? upd_m : func_pins;
        new_chain = data; new_upd = data; exp_lat = N + 3;
      end
      2'b01: begin
        exp_rsp = chain_m; check_data = chain_ok;
        new_chain = data; exp_lat = N + 1;
      end
      2'b10: begin new_out_sel = data[0]; exp_lat = 1; end
      default: exp_lat = 1;
    endcase

    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_data = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 1; got = 1'b0; se_n = 0; sh_n = 0; oe_n = 0; oe_at = 0; bad_start = 0;
    while (n <= N + 10) begin
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (se) se_n++;
      if (se && shift_sel) begin
        if (sh_n < N && start !== data[N-1-sh_n]) bad_start++;
        sh_n++;
      end else if (start) begin
        bad_start++;
      end
      if (oe) begin oe_n++; oe_at = n; end
      if (inject != 0 && n == inject) begin
        check_eq("pre_rst_se", 64'(se), 64'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_sel_m = 1'b0; last_rsp_m = '0; chain_ok = 1'b0;
        return;
      end
      if (noise) begin
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 2'($urandom_range(0, 3));
        bus.cmd_data  = rand_vec();
      end
      @(negedge clk);
      n++;
    end
    bus.cmd_valid = 1'b0;

    check_eq("rsp_seen", 64'(got), 64'd1);
    check_eq("latency", 64'(n), 64'(exp_lat));
    check_eq("se_cycles", 64'(se_n), (op == 2'b00) ? 64'(N + 1) : (op == 2'b01) ? 64'(N) : 64'd0);
    check_eq("shift_cycles", 64'(sh_n), (op[1] == 1'b0) ? 64'(N) : 64'd0);
    check_eq("oe_pulses", 64'(oe_n), (op == 2'b00) ? 64'd1 : 64'd0);
    if (op == 2'b00) check_eq("oe_cycle", 64'(oe_at), 64'(N + 2));
    check_eq("start_bits", 64'(bad_start), 64'd0);
    if (check_data) check_eq("rsp_data", 64'(bus.rsp_data), 64'(exp_rsp));
    check_eq("rsp_err", 64'(bus.rsp_err), (op == 2'b11) ? 64'd1 : 64'd0);
    check_eq("busy_ready", 64'(bus.cmd_ready), 64'd0);
    check_eq("out_sel", 64'(out_sel), 64'(new_out_sel));
    check_eq("upd_reg", 64'(upd), 64'(new_upd));

    exp_rsp = bus.rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check_eq("hold_data", 64'(bus.rsp_data), 64'(exp_rsp));
      check_eq("hold_ready", 64'(bus.cmd_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("post_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("post_ready", 64'(bus.cmd_ready), 64'd1);

    chain_m = new_chain; upd_m = new_upd; out_sel_m = new_out_sel;
    last_rsp_m = bus.rsp_data; chain_ok = 1'b1;
    if (check_data) last_rsp_m = exp_rsp;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    do_cmd(2'b00, 49'h1_5555_AAAA_0F0F, 0, 1'b0, 0);
    do_cmd(2'b10, 49'h0_0000_0000_0001, 0, 1'b0, 0);
    do_cmd(2'b01, rand_vec(), 1, 1'b1, 0);
    do_cmd(2'b00, 49'h0_0000_0000_00FF, 0, 1'b0, 0);
    do_cmd(2'b00, 49'h1_FFFF_FFFF_FF00, 10, 1'b0, 0);
    do_cmd(2'b11, rand_vec(), 2, 1'b1, 0);
    do_cmd(2'b10, 49'h0_0000_0000_0000, 0, 1'b0, 0);
    func_pins = rand_vec();
    do_cmd(2'b00, rand_vec(), 0, 1'b0, 22);
    func_pins = rand_vec();
    do_cmd(2'b00, rand_vec(), 0, 1'b0, 0);

    for (int c = 0; c < 40; c++) begin
      func_pins = rand_vec();
      do_cmd(2'($urandom_range(0, 3)), rand_vec(), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/adp_bscan_ctrl.md
ADP_BSCAN_CTRL -- requirements
Module: adp_bscan_ctrl

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 49; this is the boundary chain length and must be at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-005 SHALL have port cmd_ready, output, 1 bit: a command can be accepted.
REQ-006 SHALL have port cmd_op, input, 2 bits: 00 = SCAN (capture, shift, update); 01 = SHIFT_ONLY; 10 = SET_MODE; 11 = reserved.
REQ-007 SHALL have port cmd_data, input, NUM_CELLS bits: bit i is the value destined for chain cell i.
REQ-008 SHALL have port rsp_valid, input... correction: rsp_valid, output, 1 bit: the response is held.
REQ-009 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-010 SHALL have port rsp_data, output, NUM_CELLS bits: bit i is the value read out of chain cell i.
REQ-011 SHALL have port rsp_err, output, 1 bit: the command was reserved and has been rejected.
REQ-012 SHALL have port adp_bscan_start, output, 1 bit: serial data into cell 0.
REQ-013 SHALL have port adp_bscan_se, output, 1 bit: shift/capture register enable.
REQ-014 SHALL have port adp_bscan_shift_sel, output, 1 bit: 1 = shift from the previous cell; 0 = capture the pin.
REQ-015 SHALL have port adp_bscan_oe, output, 1 bit: load the update register from the shift register.
REQ-016 SHALL have port adp_bscan_out_sel, output, 1 bit: 1 = pins are driven from the update register; 0 = functional passthrough.
REQ-017 SHALL have port adp_bscan_end, input, 1 bit: serial data out of cell NUM_CELLS-1.

Function
REQ-018 SHALL implement FSM states IDLE, CAPTURE, SHIFT, UPDATE and RESP.
REQ-019 SHALL drive cmd_ready = 1 only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready, and cmd_op and cmd_data are latched on that cycle.
REQ-020 SHALL make these transitions from IDLE on accept: SCAN -> CAPTURE; SHIFT_ONLY -> SHIFT; SET_MODE -> RESP; reserved -> RESP with rsp_err = 1.
REQ-021 SHALL hold CAPTURE for exactly 1 cycle with se = 1 and shift_sel = 0, then go to SHIFT.
REQ-022 SHALL hold SHIFT for exactly NUM_CELLS cycles with se = 1 and shift_sel = 1, counted by a $clog2(NUM_CELLS)-bit counter that is cleared on SHIFT entry.
REQ-023 SHALL, on SHIFT cycle k (k = 0..NUM_CELLS-1), drive adp_bscan_start = latched cmd_data[NUM_CELLS-1-k] and sample adp_bscan_end into rsp_data[NUM_CELLS-1-k] at the closing clock edge.
REQ-024 SHALL exit SHIFT to UPDATE for SCAN and to RESP for SHIFT_ONLY when counter == NUM_CELLS-1; the counter never wraps.
REQ-025 SHALL hold UPDATE for exactly 1 cycle with oe = 1 and se = 0, then go to RESP.
REQ-026 SHALL drive se = 0, oe = 0, shift_sel = 0 and start = 0 in every state not listed in REQ-021 to REQ-025.
REQ-027 SHALL, for SET_MODE, load adp_bscan_out_sel from cmd_data[0] at the accept edge, so the new value is visible from the next cycle; out_sel is otherwise held across all commands.
REQ-028 SHALL, in RESP, hold rsp_valid = 1 with rsp_data and rsp_err stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-029 SHALL not accept a new command in the cycle a response is accepted; the earliest next accept is one cycle later.
REQ-030 SHALL hold rsp_data unchanged for SET_MODE and reserved commands; rsp_err SHALL be 0 for all valid ops.
REQ-031 SHALL meet these latencies, counting acceptance as cycle t: SCAN rsp_valid at t+NUM_CELLS+3; SHIFT_ONLY at t+NUM_CELLS+1; SET_MODE or reserved at t+1.
REQ-032 SHALL ignore cmd_valid in all states other than IDLE.

Reset
REQ-033 SHALL, while rst = 1, immediately force state IDLE, cmd_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_data = 0, counter = 0, and start/se/oe/shift_sel/out_sel = 0.
REQ-034 SHALL, when reset is asserted mid-SHIFT or mid-UPDATE, abort the operation with no further se/oe pulse; the partial chain contents are left undefined to software.

Verification
REQ-035 SHALL pass this scenario: out of reset, SCAN with cmd_data = 49'h1_5555_AAAA_0F0F (loop-back model end = start delayed 49) -> se high 50 cycles, oe pulse at t+51, rsp_valid at t+52, rsp_data = 0.
REQ-036 SHALL pass this scenario: two back-to-back SCANs, first 49'h0_0000_0000_00FF then 49'h1_FFFF_FFFF_FF00 -> second rsp_data = 49'h0_0000_0000_00FF.
REQ-037 SHALL pass this scenario: SET_MODE cmd_data[0] = 1, then SHIFT_ONLY -> out_sel = 1 from t+1 and stays 1; oe never pulses during SHIFT_ONLY; rsp_valid at t+50.
REQ-038 SHALL pass this scenario: reserved op 11 -> rsp_valid at t+1, rsp_err = 1, no se/oe activity, rsp_data unchanged.
REQ-039 SHALL pass this scenario: rsp_ready held 0 for 10 cycles after rsp_valid -> rsp_valid, rsp_data and cmd_ready = 0 all stable; accept happens on the rsp_ready cycle, then IDLE.
REQ-040 SHALL pass this scenario: rst asserted asynchronously at SHIFT cycle 20 -> all outputs reach their reset values without waiting for a clock edge; a fresh SCAN afterwards completes normally.
